mem8x8_host_ctrl: RTL and testbench



---
 rtl/mem8x8_host_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem8x8_host_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem8x8_host_ctrl.sv
// Host-side initiator for the 8x8 memory: clears memory after reset, then runs single
// read/write transactions as a setup phase followed by a select strobe, and returns a response.
module mem8x8_host_ctrl #(
  parameter int         STROBE_CYCLES = 1,
  parameter bit         INIT_EN       = 1'b1,
  parameter logic [7:0] INIT_VALUE    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_write,
  output logic [7:0] rsp_data,
  output logic       init_done,
  output logic [2:0] mem_address,
  output logic [7:0] mem_data_in,
  output logic       mem_rw,
  output logic       mem_select,
  input  logic [7:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_INIT_SETUP,
    S_INIT_STROBE,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RESP
  } state_t;

  localparam state_t     RESET_STATE = INIT_EN ? S_INIT_SETUP : S_IDLE;
  localparam logic [1:0] STROBE_LAST = 2'(STROBE_CYCLES - 1);

  state_t     state, state_d;
  logic [1:0] scnt, scnt_d;
  logic [2:0] cnt, cnt_d;
  logic       lat_write, lat_write_d;
  logic [7:0] lat_wdata, lat_wdata_d;

  logic       req_ready_d, rsp_valid_d, rsp_write_d, init_done_d;
  logic [7:0] rsp_data_d, mem_data_in_d;
  logic [2:0] mem_address_d;
  logic       mem_rw_d, mem_select_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_STATE;
      scnt        <= '0;
      cnt         <= '0;
      lat_write   <= 1'b0;
      lat_wdata   <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_data    <= '0;
      init_done   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_rw      <= 1'b0;
      mem_select  <= 1'b0;
    end else begin
      state       <= state_d;
      scnt        <= scnt_d;
      cnt         <= cnt_d;
      lat_write   <= lat_write_d;
      lat_wdata   <= lat_wdata_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_write   <= rsp_write_d;
      rsp_data    <= rsp_data_d;
      init_done   <= init_done_d;
      mem_address <= mem_address_d;
      mem_data_in <= mem_data_in_d;
      mem_rw      <= mem_rw_d;
      mem_select  <= mem_select_d;
    end
  end

  // Outputs are computed for the state being entered, so every output is a flop.
  always_comb begin
    state_d       = state;
    scnt_d        = scnt;
    cnt_d         = cnt;
    lat_write_d   = lat_write;
    lat_wdata_d   = lat_wdata;
    req_ready_d   = 1'b0;
    rsp_valid_d   = rsp_valid;
    rsp_write_d   = rsp_write;
    rsp_data_d    = rsp_data;
    init_done_d   = init_done;
    mem_address_d = mem_address;
    mem_data_in_d = mem_data_in;
    mem_rw_d      = mem_rw;
    mem_select_d  = 1'b0;

    case (state)
      S_INIT_SETUP: begin
        state_d       = S_INIT_STROBE;
        scnt_d        = '0;
        mem_address_d = cnt;
        mem_data_in_d = INIT_VALUE;
        mem_rw_d      = 1'b1;
        mem_select_d  = 1'b1;
      end
      S_INIT_STROBE: begin
        if (scnt == STROBE_LAST) begin
          if (cnt == 3'd7) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            init_done_d = 1'b1;
            req_ready_d = 1'b1;
          end else begin
            state_d       = S_INIT_SETUP;
            cnt_d         = cnt + 3'd1;
            mem_address_d = cnt + 3'd1;
            mem_data_in_d = INIT_VALUE;
            mem_rw_d      = 1'b1;
          end
        end else begin
          scnt_d       = scnt + 2'd1;
          mem_select_d = 1'b1;
        end
      end
      S_IDLE: begin
        init_done_d = 1'b1;
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          state_d       = S_SETUP;
          req_ready_d   = 1'b0;
          lat_write_d   = req_write;
          lat_wdata_d   = req_wdata;
          mem_address_d = req_addr;
          mem_data_in_d = req_wdata;
          mem_rw_d      = req_write;
        end
      end
      S_SETUP: begin
        state_d      = S_STROBE;
        scnt_d       = '0;
        mem_select_d = 1'b1;
      end
      S_STROBE: begin
        if (scnt == STROBE_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = lat_write;
          rsp_data_d  = lat_write ? lat_wdata : mem_data_out;
        end else begin
          scnt_d       = scnt + 2'd1;
          mem_select_d = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

endmodule

// File: tb/tb_mem8x8_host_ctrl.sv
// Bench for mem8x8_host_ctrl: two instances (1-cycle and 3-cycle strobe) on behavioural
// memories, randomized requests, scoreboard-checked responses and select-protocol monitors.
module tb_mem8x8_host_ctrl;

  localparam int         S_A  = 1;
  localparam logic [7:0] IV_A = 8'h5A;
  localparam int         S_B  = 3;
  localparam logic [7:0] IV_B = 8'hC7;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_write, init_done;
  logic [2:0] req_addr, mem_address;
  logic [7:0] req_wdata, rsp_data, mem_data_in, mem_data_out;
  logic       mem_rw, mem_select;

  logic       req_valid_b, req_ready_b, req_write_b, rsp_valid_b, rsp_ready_b, rsp_write_b, init_done_b;
  logic [2:0] req_addr_b, mem_address_b;
  logic [7:0] req_wdata_b, rsp_data_b, mem_data_in_b, mem_data_out_b;
  logic       mem_rw_b, mem_select_b;

  mem8x8_host_ctrl #(.STROBE_CYCLES(S_A), .INIT_EN(1'b1), .INIT_VALUE(IV_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_data(rsp_data),
    .init_done(init_done),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_rw(mem_rw),
    .mem_select(mem_select), .mem_data_out(mem_data_out)
  );

  mem8x8_host_ctrl #(.STROBE_CYCLES(S_B), .INIT_EN(1'b1), .INIT_VALUE(IV_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_write(rsp_write_b), .rsp_data(rsp_data_b),
    .init_done(init_done_b),
    .mem_address(mem_address_b), .mem_data_in(mem_data_in_b), .mem_rw(mem_rw_b),
    .mem_select(mem_select_b), .mem_data_out(mem_data_out_b)
  );

  // Behavioural 8x8 memories: write on the edge while selected, read is combinational.
  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];
  always @(posedge clk) if (mem_select && mem_rw) mem_a[mem_address] <= mem_data_in;
  always @(posedge clk) if (mem_select_b && mem_rw_b) mem_b[mem_address_b] <= mem_data_in_b;
  assign mem_data_out   = mem_a[mem_address];
  assign mem_data_out_b = mem_b[mem_address_b];

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic w; logic [7:0] d; } exp_t;
  typedef struct { logic [2:0] a; logic rw; } pulse_t;
  exp_t       q_a[$];
  exp_t       q_b[$];
  pulse_t     pulses_a[$];
  logic [7:0] model_a [8];
  logic [7:0] model_b [8];

  // Select monitor A: address/data/rw frozen while select is high, pulse width, pulse log.
  initial begin
    int wid = 0;
    bit psel = 0;
    logic [11:0] pv = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wid = 0;
        pulses_a.delete();
      end else if (mem_select) begin
        if (psel) check("sel_hold_a", 32'({mem_address, mem_data_in, mem_rw}), 32'(pv));
        else pulses_a.push_back('{mem_address, mem_rw});
        wid++;
      end else if (psel) begin
        check("sel_width_a", wid, S_A);
        wid = 0;
      end
      psel = rst_n && mem_select;
      pv = {mem_address, mem_data_in, mem_rw};
    end
  end

  initial begin
    int wid = 0;
    bit psel = 0;
    logic [11:0] pv = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wid = 0;
      end else if (mem_select_b) begin
        if (psel) check("sel_hold_b", 32'({mem_address_b, mem_data_in_b, mem_rw_b}), 32'(pv));
        wid++;
      end else if (psel) begin
        check("sel_width_b", wid, S_B);
        wid = 0;
      end
      psel = rst_n && mem_select_b;
      pv = {mem_address_b, mem_data_in_b, mem_rw_b};
    end
  end

  // Response monitors: pop the scoreboard on each handshake, check stability while stalled.
  initial begin
    exp_t e;
    bit pvld = 0, prdy = 0;
    logic [8:0] pd = '0;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (q_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected_a: got data %0h, expected no response", rsp_data);
        end else begin
          e = q_a.pop_front();
          check("rsp_write_a", 32'(rsp_write), 32'(e.w));
          check("rsp_data_a", 32'(rsp_data), 32'(e.d));
        end
      end
      if (rst_n && rsp_valid && pvld && !prdy)
        check("rsp_stable_a", 32'({rsp_write, rsp_data}), 32'(pd));
      pvld = rst_n && rsp_valid;
      prdy = rsp_ready;
      pd = {rsp_write, rsp_data};
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid_b && rsp_ready_b) begin
        if (q_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected_b: got data %0h, expected no response", rsp_data_b);
        end else begin
          e = q_b.pop_front();
          check("rsp_write_b", 32'(rsp_write_b), 32'(e.w));
          check("rsp_data_b", 32'(rsp_data_b), 32'(e.d));
        end
      end
    end
  end

  task automatic wait_init_a();
    int n = 0;
    bit early = 0;
    while (!init_done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (req_ready && !init_done) early = 1;
    end
    check("init_len_a", n, 8 * (1 + S_A));
    check("init_ready_low_a", 32'(early), 0);
    check("init_req_ready_a", 32'(req_ready), 1);
    check("init_pulses_a", pulses_a.size(), 8);
    for (int i = 0; i < 8 && i < pulses_a.size(); i++) begin
      check("init_pulse_addr_a", 32'(pulses_a[i].a), i);
      check("init_pulse_rw_a", 32'(pulses_a[i].rw), 1);
    end
    for (int i = 0; i < 8; i++) model_a[i] = IV_A;
  endtask

  task automatic wait_init_b();
    int n = 0;
    while (!init_done_b && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_len_b", n, 8 * (1 + S_B));
    for (int i = 0; i < 8; i++) model_b[i] = IV_B;
  endtask

  task automatic send_a(input logic w, input logic [2:0] a, input logic [7:0] d, input bit expect_rsp);
    int n = 0;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_accept_a", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 3'($urandom);
    req_wdata = 8'($urandom);
    if (expect_rsp) begin
      if (w) model_a[a] = d;
      q_a.push_back('{w, model_a[a]});
    end
  endtask

  // Latency is counted in edges from the accepting edge to the edge that first samples rsp_valid.
  task automatic collect_a(input int stall);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_latency_a", n + 1, S_A + 2);
    repeat (stall) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      check("req_ready_busy_a", 32'(req_ready), 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_after_rsp_a", 32'({req_ready, rsp_valid}), 32'h2);
  endtask

  task automatic xfer_a(input logic w, input logic [2:0] a, input logic [7:0] d, input int stall);
    send_a(w, a, d, 1'b1);
    collect_a(stall);
  endtask

  task automatic xfer_b(input logic w, input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    req_write_b = w;
    req_addr_b  = a;
    req_wdata_b = d;
    req_valid_b = 1'b1;
    while (!req_ready_b && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_accept_b", 32'(req_ready_b), 1);
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    if (w) model_b[a] = d;
    q_b.push_back('{w, model_b[a]});
    n = 0;
    while (!rsp_valid_b && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_latency_b", n + 1, S_B + 2);
    rsp_ready_b = 1'b1;
    @(posedge clk); #1;
    rsp_ready_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_a", 32'({req_ready, rsp_valid, rsp_write, rsp_data, init_done,
                               mem_address, mem_data_in, mem_rw, mem_select}), 0);
    check("reset_outs_b", 32'({req_ready_b, rsp_valid_b, init_done_b, mem_select_b, mem_rw_b}), 0);
    rst_n = 1'b1;
    fork
      wait_init_a();
      wait_init_b();
    join

    xfer_a(1'b0, 3'd3, 8'h00, 0);
    xfer_a(1'b1, 3'd0, 8'hAA, 0);
    xfer_a(1'b0, 3'd0, 8'h00, 0);
    xfer_a(1'b1, 3'd1, 8'h55, 1);
    xfer_a(1'b0, 3'd0, 8'h00, 0);
    xfer_a(1'b0, 3'd1, 8'h00, 5);
    xfer_a(1'b1, 3'd7, 8'hE1, 5);

    for (int i = 0; i < 40; i++)
      xfer_a(1'($urandom), 3'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    xfer_b(1'b1, 3'd5, 8'hC3);
    xfer_b(1'b0, 3'd5, 8'h00);
    xfer_b(1'b0, 3'd6, 8'h00);
    for (int i = 0; i < 8; i++) xfer_b(1'($urandom), 3'($urandom), 8'($urandom));

    // Reset in the middle of a write strobe: select must drop at once and no response follows.
    send_a(1'b1, 3'd2, 8'h3C, 1'b0);
    @(posedge clk); #3;
    check("strobe_before_rst_a", 32'({mem_select, mem_address, mem_rw}), 32'({1'b1, 3'd2, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("rst_async_outs_a", 32'({req_ready, rsp_valid, init_done, mem_select, mem_rw, mem_address}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fork
      wait_init_a();
      wait_init_b();
    join
    xfer_a(1'b0, 3'd2, 8'h00, 0);
    xfer_a(1'b0, 3'd0, 8'h00, 0);
    xfer_b(1'b0, 3'd5, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty_a", q_a.size(), 0);
    check("sb_empty_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
